// File: rtl/fetch.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, and an
// in-order {instr, pc} queue that feeds decode.
module fetch #(
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    BUF_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    input  logic                   instr_ready
);
    localparam int              CW      = $clog2(BUF_DEPTH + 1);
    localparam int              PW      = $clog2(BUF_DEPTH);
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(BUF_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0]  r_fetch_pc;
    logic [ADDR_WIDTH-1:0]  r_resp_pc;
    logic [CW-1:0]          r_out_cnt;
    logic [CW-1:0]          r_drop_cnt;
    logic [CW-1:0]          r_count;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic [INSTR_WIDTH-1:0] r_buf_instr [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0]  r_buf_pc    [BUF_DEPTH];

    logic [CW:0]            w_credit_sum;
    logic                   w_empty;
    logic                   w_show;
    logic                   w_req_fire;
    logic                   w_pop;
    logic                   w_resp_keep;
    logic                   w_resp_drop;
    logic [ADDR_WIDTH-1:0]  w_redirect_pc;
    logic                   w_unused_pc_lsb;

    // Both handshakes are plain valid/ready: a transfer happens on a rising edge
    // where valid and ready are both high; valid never waits on ready.
    assign w_credit_sum   = {1'b0, r_out_cnt} + {1'b0, r_count};
    assign imem_req_valid = !rst && !redirect_valid && (w_credit_sum < DEPTH_W);
    assign imem_req_addr  = rst ? '0 : r_fetch_pc;

    assign w_empty     = (r_count == '0);
    assign w_show      = !rst && !w_empty;
    assign instr_valid = w_show && !redirect_valid;
    assign instr_out   = w_show ? r_buf_instr[r_rd_ptr] : '0;
    assign pc_out      = w_show ? r_buf_pc[r_rd_ptr] : '0;

    assign w_req_fire    = imem_req_valid && imem_req_ready;
    assign w_pop         = instr_valid && instr_ready;
    assign w_resp_keep   = imem_resp_valid && !redirect_valid && (r_drop_cnt == '0);
    assign w_resp_drop   = imem_resp_valid && !redirect_valid && (r_drop_cnt != '0);
    assign w_redirect_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused_pc_lsb = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_out_cnt <= r_out_cnt + CW'(w_req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                // Everything still in flight belongs to the old path; a response
                // arriving right now is already accounted for by being dropped here.
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_drop_cnt <= r_out_cnt - CW'(imem_resp_valid);
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + STEP;
                end
                if (w_resp_drop) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_resp_keep) begin
                    r_wr_ptr  <= r_wr_ptr + PW'(1);
                    r_resp_pc <= r_resp_pc + STEP;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= r_count + CW'(w_resp_keep) - CW'(w_pop);
            end
        end
    end

    // Queue storage needs no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_resp_keep) begin
            r_buf_instr[r_wr_ptr] <= imem_resp_data;
            r_buf_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end
endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage with a fixed-latency in-order memory model
// and an in-order delivery scoreboard of {pc, instr}.
module tb_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_ready;

    fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;
    int n_acc    = 0;
    int n_deliv  = 0;

    logic        s_req_valid;
    logic        s_ivalid;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [63:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory returns the bitwise complement of the address as the instruction word.
    function automatic logic [63:0] entry(input logic [31:0] pc);
        return {pc, ~pc};
    endfunction

    task automatic load_exp(input logic [31:0] start, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(entry(start + 32'(4 * k)));
    endtask

    task automatic drive_resp();
        if (mq_addr.size() > 0 && mq_due[0] == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~mq_addr[0];
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    endtask

    // Called at the falling edge with this cycle's inputs set; returns at the next
    // falling edge with s_* holding the samples of the cycle just completed.
    task automatic cycle();
        #1;
        s_req_valid = imem_req_valid;
        s_addr      = imem_req_addr;
        s_ivalid    = instr_valid;
        s_pc        = pc_out;
        s_instr     = instr_out;
        if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
            n_acc++;
        end
        if (instr_valid && instr_ready) begin
            n_deliv++;
            if (exp_q.size() == 0) check_eq("unexpected_pop", {pc_out, instr_out}, 64'hDEAD);
            else check_eq("deliver", {pc_out, instr_out}, exp_q.pop_front());
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
        end
        drive_resp();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        cycle();
        cycle();
        rst = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        exp_q.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        n_acc   = 0;
        n_deliv = 0;
        cyc     = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // Reset state and streaming at L=1.
        do_reset();
        check_eq("rst_req_valid", s_req_valid, 0);
        check_eq("rst_instr_valid", s_ivalid, 0);
        check_eq("rst_pc_out", s_pc, 0);
        check_eq("rst_instr_out", s_instr, 0);
        check_eq("rst_req_addr", s_addr, 0);
        lat = 1;
        load_exp(32'h0, 8);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i == 0) begin
                check_eq("first_req_valid", s_req_valid, 1);
                check_eq("first_req_addr", s_addr, 32'h0);
            end
            check_eq($sformatf("stream_valid_c%0d", i), s_ivalid, (i >= 2));
        end
        check_eq("stream_count", n_deliv, 8);

        // Backpressure: decode stalled, four requests fill the queue.
        do_reset();
        lat = 1;
        instr_ready = 1'b0;
        load_exp(32'h0, 16);
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i >= 4) check_eq($sformatf("bp_req_off_c%0d", i), s_req_valid, 0);
        end
        check_eq("bp_accepted", n_acc, 4);
        check_eq("bp_head_valid", s_ivalid, 1);
        check_eq("bp_head_pc", s_pc, 32'h0);
        check_eq("bp_no_pop", n_deliv, 0);
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        check_eq("bp_drained", (n_deliv >= 4), 1);

        // Redirect with two responses in flight at L=3.
        do_reset();
        lat = 3;
        load_exp(32'h100, 8);
        cycle();
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h101;
        cycle();
        check_eq("redir_req_blocked", s_req_valid, 0);
        check_eq("redir_ivalid_low", s_ivalid, 0);
        redirect_valid = 1'b0;
        cycle();
        check_eq("redir_new_req_valid", s_req_valid, 1);
        check_eq("redir_new_addr", s_addr, 32'h100);
        for (int i = 4; i < 7; i++) begin
            cycle();
            check_eq($sformatf("redir_empty_c%0d", i), s_ivalid, 0);
        end
        cycle();
        check_eq("redir_first_valid", s_ivalid, 1);
        check_eq("redir_first_pc", s_pc, 32'h100);
        for (int i = 0; i < 6; i++) cycle();
        check_eq("redir_deliv", (n_deliv >= 2), 1);

        // Redirect coinciding with a response and a would-be pop, L=2.
        do_reset();
        lat = 2;
        exp_q.push_back(entry(32'h0));
        exp_q.push_back(entry(32'h4));
        load_exp(32'h40, 8);
        for (int i = 0; i < 5; i++) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cycle();
        check_eq("coinc_ivalid_low", s_ivalid, 0);
        check_eq("coinc_req_low", s_req_valid, 0);
        redirect_valid = 1'b0;
        cycle();
        check_eq("coinc_queue_empty", s_ivalid, 0);
        check_eq("coinc_new_addr", s_addr, 32'h40);
        for (int i = 7; i < 9; i++) begin
            cycle();
            check_eq($sformatf("coinc_wait_c%0d", i), s_ivalid, 0);
        end
        cycle();
        check_eq("coinc_valid_c9", s_ivalid, 1);
        check_eq("coinc_pc_c9", s_pc, 32'h40);
        check_eq("coinc_deliv", n_deliv, 3);

        // Memory stall: imem_req_ready low for five cycles.
        do_reset();
        lat = 1;
        load_exp(32'h0, 16);
        cycle();
        cycle();
        imem_req_ready = 1'b0;
        for (int i = 2; i < 7; i++) begin
            cycle();
            check_eq($sformatf("stall_valid_c%0d", i), s_req_valid, 1);
            check_eq($sformatf("stall_addr_c%0d", i), s_addr, 32'h8);
        end
        imem_req_ready = 1'b1;
        cycle();
        check_eq("stall_resume_addr", s_addr, 32'h8);
        check_eq("stall_accepted", n_acc, 3);
        for (int i = 0; i < 8; i++) cycle();
        check_eq("stall_deliv", (n_deliv >= 5), 1);

        // Reset mid-stream with the queue partly full and a request in flight.
        do_reset();
        lat = 2;
        instr_ready = 1'b0;
        load_exp(32'h0, 16);
        for (int i = 0; i < 5; i++) cycle();
        check_eq("mid_pre_valid", s_ivalid, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        instr_ready = 1'b1;
        exp_q.delete();
        load_exp(32'h0, 16);
        n_deliv = 0;
        cycle();
        check_eq("mid_ivalid_low", s_ivalid, 0);
        check_eq("mid_req_valid", s_req_valid, 1);
        check_eq("mid_req_addr", s_addr, 32'h0);
        for (int i = 0; i < 10; i++) cycle();
        check_eq("mid_restream", (n_deliv >= 6), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
